uart_rx: RTL and testbench
==========================

# uart_rx

Serial receive counterpart of the design's UART transmitter. Deserialises 8N1 frames arriving on `uart_in` and deposits each received byte into data memory through the shared DMEM port. While it drives that port it raises `intr`, using the same bus-steal mechanism the transmitter uses. Software polls a memory-mapped receive counter and reads bytes from a ring buffer in data memory.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per serial bit; must be >= 8.
- `BUF_BASE`, default 32'h0000_3000: byte address of ring-buffer word 0.
- `BUF_DEPTH`, default 16: ring-buffer entries, one 32-bit word each; power of two, >= 2.
- `CNT_ADDR`, default 32'h0000_2FFC: byte address of the received-byte counter word.
- `clk` in 1: the single clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `uart_in` in 1: serial line, idle high; asynchronous to `clk`.
- `intr` out 1: high while this block owns the DMEM port.
- `wen` out 1: DMEM write enable.
- `addr_d` out `WORD_LEN`: DMEM byte address.
- `wdata` out `WORD_LEN`: DMEM write data.
- `frame_err` out 1: one-cycle pulse when a frame is rejected for a bad stop bit.

## Operation
- **Input synchroniser.** `uart_in` passes through a 2-flop synchroniser before use. Reset value of both flops is 1. All decisions use the synchronised value `rx_s`.
- **State machine.** States are IDLE, START, DATA, STOP, WR_DATA and WR_CNT. A baud counter `bcnt` counts clock cycles within a bit. A bit index `bidx` (0..7) tracks the current data bit.
- **IDLE.** `bcnt` is held at 0. When `rx_s` is 0, go to START.
- **START.** Wait `CLKS_PER_BIT/2` cycles (integer floor), then sample `rx_s`.
  - Sample is 0: go to DATA with `bcnt` = 0 and `bidx` = 0.
  - Sample is 1: treat as a glitch and return to IDLE. No write, no error.
- **DATA.** Every `CLKS_PER_BIT` cycles, sample `rx_s` into `shift[bidx]`. Bits arrive LSB first. After bit 7, go to STOP.
- **STOP.** After `CLKS_PER_BIT` cycles, sample `rx_s`.
  - Sample is 1: go to WR_DATA.
  - Sample is 0: pulse `frame_err` for 1 cycle, discard the byte and go to IDLE.
    - A framing error does not advance `wr_ptr` or `rx_cnt`.
    - The line must return high before a new start is detected, because IDLE acts on any 0. A stuck-low line therefore re-enters START, then DATA, and produces repeated `frame_err` pulses.
- **WR_DATA (1 cycle).** Drive `intr`=1 and `wen`=1.
  - `addr_d` = `BUF_BASE` + 4·`wr_ptr`.
  - `wdata` = {24'b0, byte}.
  - Then go to WR_CNT.
- **WR_CNT (1 cycle).** Drive `intr`=1 and `wen`=1.
  - `addr_d` = `CNT_ADDR`.
  - `wdata` = `rx_cnt`+1.
  - Update the registers: `rx_cnt` ← `rx_cnt`+1 (32-bit, wraps 2^32−1 → 0) and `wr_ptr` ← (`wr_ptr`+1) mod `BUF_DEPTH`.
  - Then go to IDLE.
- **Register widths.** `wr_ptr` is log2(`BUF_DEPTH`) bits. `rx_cnt` is 32 bits.
- **Overflow.** There is no flow control. If software falls behind, older ring entries are overwritten. Software detects this by comparing `rx_cnt` against its own read count.
- **Idle outputs.** Outside WR_DATA and WR_CNT, `intr`, `wen`, `addr_d` and `wdata` are all 0.
- **Reset.** Synchronous `rst_n`=0 takes effect at the next edge, including mid-frame or mid-write:
  - State → IDLE.
  - `bcnt`, `bidx`, `shift`, `wr_ptr`, `rx_cnt` → 0.
  - Outputs `intr`, `wen`, `addr_d`, `wdata`, `frame_err` → 0.
  - Synchroniser flops → 1.
  - A partially received frame is discarded.

## Timing
- **Synchroniser latency.** 2 cycles from a `uart_in` edge to `rx_s`.
- **Sample points.** With the falling edge of the start bit visible on `rx_s` at cycle t0:
  - Start-bit check at t0 + `CLKS_PER_BIT/2`.
  - Data bit k sampled at t0 + `CLKS_PER_BIT/2` + (k+1)·`CLKS_PER_BIT`.
  - Stop bit sampled at t0 + `CLKS_PER_BIT/2` + 9·`CLKS_PER_BIT`.
- **Writes.** WR_DATA is the cycle after the stop sample; WR_CNT follows it. `intr` is high for exactly 2 consecutive cycles per accepted byte.
- **Memory write.** Data memory writes on the clock edge that ends each cycle in which `wen`=1.
- **Back-to-back frames.** The write phase takes 2 cycles, well inside the remaining half stop bit (`CLKS_PER_BIT` >= 8). A start bit immediately after the stop bit is therefore never missed.
- **Output timing.** `frame_err` is asserted in the cycle after the stop sample, i.e. the cycle in which the FSM is in IDLE. All outputs are registered.

## Test plan
- **Single byte.** `CLKS_PER_BIT`=8, send 0x55. Required response:
  - Exactly 2 cycles of `intr`.
  - 32'h0000_0055 written to 32'h3000.
  - 32'h1 written to 32'h2FFC.
  - `frame_err` stays 0.
- **Back-to-back bytes.** Send 0xA5 then 0x3C with no idle gap. Required response: 32'h000000A5 @ 32'h3000, 32'h3C @ 32'h3004, and the counter is written with 1 and then 2.
- **Ring wrap.** Send 17 bytes 0x00..0x10. Required response: byte 0x10 is written to 32'h3000 (overwriting 0x00), and the counter word is written with 17.
- **Framing error.** Send a frame with the stop bit 0. Required response: one `frame_err` pulse, no `wen`, and the next valid byte is still written to `BUF_BASE`+4·(current `wr_ptr`).
- **Start glitch.** Pull `uart_in` low for 2 cycles only. Required response: return to IDLE, no write, no `frame_err`.
- **Reset mid-frame.** Assert `rst_n`=0 for 1 cycle during DATA bit 4, then send 0x81. Required response: all outputs 0 during and after reset, and 0x81 is written to 32'h3000 with counter value 1.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 serial receiver: deposits each byte into a DMEM ring buffer, then bumps a counter word.
// Two-cycle bus steal (intr) per accepted byte; no flow control, so old ring entries are overwritten.
module uart_rx #(
  parameter int          CLKS_PER_BIT = 434,
  parameter logic [31:0] BUF_BASE     = 32'h0000_3000,
  parameter int          BUF_DEPTH    = 16,
  parameter logic [31:0] CNT_ADDR     = 32'h0000_2FFC,
  parameter int          WORD_LEN     = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                uart_in,
  output logic                intr,
  output logic                wen,
  output logic [WORD_LEN-1:0] addr_d,
  output logic [WORD_LEN-1:0] wdata,
  output logic                frame_err
);

  localparam int BW = $clog2(CLKS_PER_BIT + 1);
  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam logic [BW-1:0] BIT_LAST  = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] HALF_LAST = BW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WR_DATA,
    WR_CNT
  } state_t;

  state_t          state;
  logic            rx_m;
  logic            rx_s;
  logic [BW-1:0]   bcnt;
  logic [2:0]      bidx;
  logic [7:0]      shift;
  logic [PW-1:0]   wr_ptr;
  logic [31:0]     rx_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= uart_in;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      bcnt      <= '0;
      bidx      <= '0;
      shift     <= '0;
      wr_ptr    <= '0;
      rx_cnt    <= '0;
      intr      <= 1'b0;
      wen       <= 1'b0;
      addr_d    <= '0;
      wdata     <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          bcnt <= '0;
          if (!rx_s) state <= START;
        end

        START: begin
          if (bcnt == HALF_LAST) begin
            bcnt  <= '0;
            bidx  <= '0;
            // A line that is high again by mid start bit was only a glitch.
            state <= rx_s ? IDLE : DATA;
          end else begin
            bcnt <= bcnt + BW'(1);
          end
        end

        DATA: begin
          if (bcnt == BIT_LAST) begin
            bcnt        <= '0;
            shift[bidx] <= rx_s;
            bidx        <= bidx + 3'd1;
            if (bidx == 3'd7) state <= STOP;
          end else begin
            bcnt <= bcnt + BW'(1);
          end
        end

        STOP: begin
          if (bcnt == BIT_LAST) begin
            bcnt <= '0;
            if (rx_s) begin
              state  <= WR_DATA;
              intr   <= 1'b1;
              wen    <= 1'b1;
              addr_d <= WORD_LEN'(BUF_BASE) + WORD_LEN'({wr_ptr, 2'b00});
              wdata  <= WORD_LEN'(shift);
            end else begin
              frame_err <= 1'b1;
              state     <= IDLE;
            end
          end else begin
            bcnt <= bcnt + BW'(1);
          end
        end

        WR_DATA: begin
          state  <= WR_CNT;
          addr_d <= WORD_LEN'(CNT_ADDR);
          wdata  <= WORD_LEN'(rx_cnt + 32'd1);
        end

        WR_CNT: begin
          state  <= IDLE;
          intr   <= 1'b0;
          wen    <= 1'b0;
          addr_d <= '0;
          wdata  <= '0;
          rx_cnt <= rx_cnt + 32'd1;
          wr_ptr <= wr_ptr + PW'(1);
        end

        default: begin
          state  <= IDLE;
          intr   <= 1'b0;
          wen    <= 1'b0;
          addr_d <= '0;
          wdata  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Randomised bench for uart_rx against a queue-based model of the expected DMEM write stream.
module tb_uart_rx;

  localparam int          C     = 8;
  localparam logic [31:0] BASE  = 32'h0000_3000;
  localparam logic [31:0] CNTA  = 32'h0000_2FFC;
  localparam int          DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        uart_in = 1'b1;
  logic        intr;
  logic        wen;
  logic [31:0] addr_d;
  logic [31:0] wdata;
  logic        frame_err;

  uart_rx #(
    .CLKS_PER_BIT(C),
    .BUF_BASE    (BASE),
    .BUF_DEPTH   (DEPTH),
    .CNT_ADDR    (CNTA),
    .WORD_LEN    (32)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .uart_in  (uart_in),
    .intr     (intr),
    .wen      (wen),
    .addr_d   (addr_d),
    .wdata    (wdata),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: each accepted byte yields a ring write then a counter write.
  logic [63:0] exp_q[$];
  int          m_ptr   = 0;
  logic [31:0] m_cnt   = 0;
  int          exp_ferr = 0;
  int          exp_intr = 0;

  function automatic void model_byte(input logic [7:0] b);
    exp_q.push_back({BASE + 32'(4 * m_ptr), 24'b0, b});
    m_cnt = m_cnt + 32'd1;
    exp_q.push_back({CNTA, m_cnt});
    m_ptr = (m_ptr + 1) % DEPTH;
    exp_intr = exp_intr + 2;
  endfunction

  // Bus monitor, sampled on the falling edge.
  logic [63:0] obs_q[$];
  int   obs_ferr  = 0;
  int   obs_intr  = 0;
  int   bad_runs  = 0;
  int   bad_idle  = 0;
  int   bad_pulse = 0;
  int   run       = 0;
  logic fe_prev   = 1'b0;

  always @(negedge clk) begin
    if (wen) obs_q.push_back({addr_d, wdata});
    if (intr !== wen) bad_idle <= bad_idle + 1;
    else if (!intr && (addr_d !== 32'd0 || wdata !== 32'd0)) bad_idle <= bad_idle + 1;
    if (intr) begin
      run      <= run + 1;
      obs_intr <= obs_intr + 1;
    end else begin
      if (run != 0 && run != 2) bad_runs <= bad_runs + 1;
      run <= 0;
    end
    if (frame_err) begin
      obs_ferr <= obs_ferr + 1;
      if (fe_prev) bad_pulse <= bad_pulse + 1;
    end
    fe_prev <= frame_err;
  end

  task automatic hold(input logic v, input int cyc);
    uart_in = v;
    repeat (cyc) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    hold(1'b0, C);
    for (int i = 0; i < 8; i++) hold(b[i], C);
    hold(stop, C);
    uart_in = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    uart_in = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_ptr = 0;
    m_cnt = 32'd0;
  endtask

  int chk_idx = 0;

  task automatic settle_and_compare(input string tag);
    repeat (3 * C) @(negedge clk);
    check_eq({tag, "_nwr"}, obs_q.size(), exp_q.size());
    for (int i = chk_idx; i < exp_q.size() && i < obs_q.size(); i++) begin
      check_eq({tag, "_addr"}, obs_q[i][63:32], exp_q[i][63:32]);
      check_eq({tag, "_data"}, obs_q[i][31:0], exp_q[i][31:0]);
    end
    chk_idx = exp_q.size();
    check_eq({tag, "_ferr_cnt"}, obs_ferr, exp_ferr);
    check_eq({tag, "_intr_cycles"}, obs_intr, exp_intr);
    check_eq({tag, "_intr_run"}, bad_runs, 0);
    check_eq({tag, "_idle_out"}, bad_idle, 0);
    check_eq({tag, "_ferr_pulse"}, bad_pulse, 0);
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_intr"}, intr, 1'b0);
    check_eq({tag, "_wen"}, wen, 1'b0);
    check_eq({tag, "_addr"}, addr_d, 32'd0);
    check_eq({tag, "_wdata"}, wdata, 32'd0);
    check_eq({tag, "_ferr"}, frame_err, 1'b0);
  endtask

  initial begin
    logic [7:0] b;
    logic       ok;

    // Reset state
    repeat (3) @(negedge clk);
    check_quiet("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte
    send_frame(8'h55, 1'b1);
    model_byte(8'h55);
    settle_and_compare("single");

    // Back-to-back, no idle gap
    do_reset();
    send_frame(8'hA5, 1'b1);
    send_frame(8'h3C, 1'b1);
    model_byte(8'hA5);
    model_byte(8'h3C);
    settle_and_compare("b2b");

    // Ring wrap: 17 bytes, the last lands back on word 0
    do_reset();
    for (int i = 0; i <= 16; i++) begin
      b = 8'(i);
      send_frame(b, 1'b1);
      model_byte(b);
      hold(1'b1, $urandom_range(0, 2 * C));
    end
    settle_and_compare("wrap");
    check_eq("wrap_last_addr", obs_q[obs_q.size() - 2][63:32], BASE);
    check_eq("wrap_last_cnt", obs_q[obs_q.size() - 1][31:0], 32'd17);

    // Framing error between good bytes
    do_reset();
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom_range(0, 255));
      send_frame(b, 1'b1);
      model_byte(b);
    end
    send_frame(8'($urandom_range(0, 255)), 1'b0);
    exp_ferr++;
    hold(1'b1, 2 * C);
    b = 8'($urandom_range(0, 255));
    send_frame(b, 1'b1);
    model_byte(b);
    settle_and_compare("frame_err");

    // Start glitch of two cycles
    hold(1'b0, 2);
    hold(1'b1, 3 * C);
    settle_and_compare("glitch");

    // Reset during data bit 4, then a clean byte
    hold(1'b0, C);
    for (int i = 0; i < 4; i++) hold(1'b1, C);
    hold(1'b0, C / 2);
    rst_n   = 1'b0;
    uart_in = 1'b1;
    @(negedge clk);
    check_quiet("rst_mid");
    rst_n = 1'b1;
    m_ptr = 0;
    m_cnt = 32'd0;
    hold(1'b1, 2 * C);
    check_quiet("rst_after");
    send_frame(8'h81, 1'b1);
    model_byte(8'h81);
    settle_and_compare("rst_frame");

    // Random traffic with occasional bad stop bits and random gaps
    for (int i = 0; i < 40; i++) begin
      b  = 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 9) != 0);
      send_frame(b, ok);
      if (ok) begin
        model_byte(b);
        hold(1'b1, $urandom_range(0, 3 * C));
      end else begin
        exp_ferr++;
        hold(1'b1, 2 * C);
      end
    end
    settle_and_compare("random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
